// File: rtl/attn_pkg.sv
// Shared constants and state encoding for the MAC array output path.
// Lane geometry defaults are shared with the MAC array and the ofifo.
package attn_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int NIJ_MAX_DEF = 256;
  localparam int WORD_W_DEF  = COL_DEF * PSUM_BW_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    STREAM = 2'd2,
    FIN    = 2'd3
  } drain_state_e;

endpackage

// File: rtl/psum_acc_bank.sv
// Psum accumulation bank: one overwrite/accumulate write port, one registered read port.
// Read data appears one cycle after raddr; a same-cycle write to raddr is forwarded.
module psum_acc_bank
  import attn_pkg::*;
#(
  parameter int COL     = COL_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int DEPTH   = NIJ_MAX_DEF,
  localparam int AW     = $clog2(DEPTH),
  localparam int WW     = COL * PSUM_BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          acc,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] new_word;

  // Lane-wise add; each lane wraps on its own with no carry into its neighbour.
  always_comb begin
    new_word = '0;
    for (int c = 0; c < COL; c++) begin
      if (acc)
        new_word[c*PSUM_BW +: PSUM_BW] = mem[waddr][c*PSUM_BW +: PSUM_BW] + wdata[c*PSUM_BW +: PSUM_BW];
      else
        new_word[c*PSUM_BW +: PSUM_BW] = wdata[c*PSUM_BW +: PSUM_BW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= new_word;
    end
  end

  // Forwarding covers a single-word pass, where the last write and first read coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata <= '0;
    else if (we && (waddr == raddr))
      rdata <= new_word;
    else
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ofifo_psum_drain.sv
// Pops ofifo psum words, accumulates per nij across kij passes, streams the bank on the last pass (optional ReLU: PSUM_DRAIN_RELU_EN).
// Latency: first pop the cycle after start; done one cycle after the last pop/accept.
// Backpressure: ofifo_valid low stalls draining; out_ready low holds out_data stable.
module ofifo_psum_drain
  import attn_pkg::*;
#(
  parameter int COL     = COL_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int NIJ_MAX = NIJ_MAX_DEF,
  localparam int AW     = $clog2(NIJ_MAX),
  localparam int CW     = AW + 1,
  localparam int WW     = COL * PSUM_BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] num_nij,
  input  logic          first_kij,
  input  logic          last_kij,
  input  logic          ofifo_valid,
  input  logic [WW-1:0] ofifo_out,
  output logic          ofifo_rd,
  output logic [WW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  drain_state_e  state, state_nxt;
  logic [CW-1:0] n_reg;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;
  logic          first_q;
  logic          last_q;
  logic [AW-1:0] raddr;
  logic [WW-1:0] rd_dat;
  logic          accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ofifo_rd  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRAIN;
      end
      DRAIN: begin
        ofifo_rd = ofifo_valid && (rd_cnt < n_reg);
        if (ofifo_rd && (rd_cnt == n_reg - CW'(1)))
          state_nxt = last_q ? STREAM : FIN;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && (wr_cnt == n_reg - CW'(1)))
          state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = out_valid && out_ready;

  // num_nij of zero means a full bank of NIJ_MAX words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        n_reg   <= (num_nij == '0) ? CW'(NIJ_MAX) : {1'b0, num_nij};
        first_q <= first_kij;
        last_q  <= last_kij;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
      end
      if (ofifo_rd) rd_cnt <= rd_cnt + CW'(1);
      if (accept)   wr_cnt <= wr_cnt + CW'(1);
    end
  end

  // Prefetch the word after the one being accepted so streaming has no bubbles.
  assign raddr = accept ? (wr_cnt[AW-1:0] + AW'(1)) : wr_cnt[AW-1:0];

  psum_acc_bank #(
    .COL     (COL),
    .PSUM_BW (PSUM_BW),
    .DEPTH   (NIJ_MAX)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (ofifo_rd),
    .acc   (!first_q),
    .waddr (rd_cnt[AW-1:0]),
    .wdata (ofifo_out),
    .raddr (raddr),
    .rdata (rd_dat)
  );

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = rd_dat;
`ifdef PSUM_DRAIN_RELU_EN
      for (int c = 0; c < COL; c++) begin
        if (rd_dat[c*PSUM_BW + PSUM_BW - 1]) out_data[c*PSUM_BW +: PSUM_BW] = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ofifo_psum_drain.sv
// Directed-plus-random bench for ofifo_psum_drain against a per-nij, per-lane psum model.
module tb_ofifo_psum_drain;
  localparam int COL = 8;
  localparam int PW  = 16;
  localparam int WW  = COL * PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    num_nij;
  logic          first_kij;
  logic          last_kij;
  logic          ofifo_valid;
  logic [WW-1:0] ofifo_out;
  logic          ofifo_rd;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] mbank [256][COL];
  logic [WW-1:0] fq [$];
  logic [WW-1:0] last_out;

  always #5 clk = ~clk;

  ofifo_psum_drain dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_nij     (num_nij),
    .first_kij   (first_kij),
    .last_kij    (last_kij),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] word_all(input logic [PW-1:0] v);
    logic [WW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PW +: PW] = v;
    return r;
  endfunction

  function automatic logic [WW-1:0] word_lane0(input logic [PW-1:0] v);
    logic [WW-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[PW-1:0] = v;
    return r;
  endfunction

  function automatic logic [WW-1:0] exp_word(input int idx);
    logic [WW-1:0] r;
    logic [PW-1:0] v;
    for (int c = 0; c < COL; c++) begin
      v = mbank[idx][c];
`ifdef PSUM_DRAIN_RELU_EN
      if (v[PW-1]) v = '0;
`endif
      r[c*PW +: PW] = v;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++)
      for (int c = 0; c < COL; c++) mbank[i][c] = '0;
  endtask

  task automatic model_pop(input int idx, input bit first, input logic [WW-1:0] w);
    for (int c = 0; c < COL; c++) begin
      if (first) mbank[idx][c] = w[c*PW +: PW];
      else       mbank[idx][c] = mbank[idx][c] + w[c*PW +: PW];
    end
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 always ready, 1 three-cycle stall at word 2, 2 random.
  task automatic run_pass(input int n_code, input bit first, input bit last,
                          input int vmode, input int rmode, input int stop_pops);
    int n, pops, w, phase, stall_cnt;
    bit exp_rd, prev_stall, vg;
    logic [WW-1:0] prev_data, ew, popped;
    n = (n_code == 0) ? 256 : n_code;
    pops = 0; w = 0; phase = 0; stall_cnt = 0; prev_stall = 0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; num_nij = n_code[7:0]; first_kij = first; last_kij = last;
    ofifo_valid = 1'b0; out_ready = 1'b0;
    #1 chk("idle_busy", busy, 0);
    for (int cyc = 0; cyc < 4000 && phase != 3; cyc++) begin
      @(negedge clk);
      if (stop_pops >= 0 && pops == stop_pops) return;
      case (vmode)
        0:       vg = 1'b1;
        1:       vg = (cyc % 2) == 0;
        default: vg = $urandom_range(0, 3) != 0;
      endcase
      ofifo_valid = (fq.size() > 0) && vg;
      ofifo_out   = ofifo_valid ? fq[0] : {$urandom, $urandom, $urandom, $urandom};
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(phase == 1 && w == 2 && stall_cnt < 3);
        default: out_ready = $urandom_range(0, 3) != 0;
      endcase
      if (rmode == 1 && !out_ready) stall_cnt++;
      start     = ($urandom_range(0, 7) == 0);
      num_nij   = 8'($urandom);
      first_kij = 1'($urandom);
      last_kij  = 1'($urandom);
      #1;
      chk("busy", busy, 1);
      case (phase)
        0: begin
          exp_rd = ofifo_valid;
          chk("drain_rd", ofifo_rd, exp_rd);
          chk("drain_ov", out_valid, 0);
          chk("drain_done", done, 0);
          if (exp_rd) begin
            popped = fq.pop_front();
            model_pop(pops, first, popped);
            pops++;
            if (pops == n) phase = last ? 1 : 2;
          end
        end
        1: begin
          ew = exp_word(w);
          chk("stream_ov", out_valid, 1);
          chk("stream_dat", out_data, ew);
          chk("stream_rd", ofifo_rd, 0);
          if (prev_stall) chk("stream_hold", out_data, prev_data);
          prev_stall = !out_ready;
          prev_data  = out_data;
          if (out_ready) begin
            last_out = ew;
            w++;
            if (w == n) phase = 2;
          end
        end
        default: begin
          chk("fin_done", done, 1);
          chk("fin_ov", out_valid, 0);
          chk("fin_rd", ofifo_rd, 0);
          phase = 3;
        end
      endcase
    end
    chk("pass_timeout", phase, 3);
    @(negedge clk);
    start = 1'b0; ofifo_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_ov", out_valid, 0);
    chk("post_dat", out_data, 0);
  endtask

  initial begin
    logic [WW-1:0] wv;
    reset = 1'b0; start = 1'b0; num_nij = '0; first_kij = 1'b0; last_kij = 1'b0;
    ofifo_valid = 1'b0; ofifo_out = '0; out_ready = 1'b0; last_out = '0;
    model_clear();
    repeat (3) @(negedge clk);
    ofifo_valid = 1'b1;
    #1;
    chk("rst_rd", ofifo_rd, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_dat", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1; ofifo_valid = 1'b0;

    // Single overwrite+stream pass.
    for (int k = 1; k <= 4; k++) fq.push_back(word_all(PW'(k)));
    run_pass(4, 1, 1, 0, 0, -1);
    chk("t1_fq_left", fq.size(), 0);
    chk("t1_last", last_out, word_all(16'd4));

    // Three-pass accumulation; pass-2 words are queued early to catch over-popping.
    for (int k = 0; k < 3; k++) fq.push_back(word_lane0(16'd5));
    for (int k = 0; k < 3; k++) fq.push_back(word_lane0(16'hFFFE));
    run_pass(3, 1, 0, 0, 0, -1);
    chk("t2_no_overpop", fq.size(), 3);
    run_pass(3, 0, 0, 2, 0, -1);
    for (int k = 0; k < 3; k++) fq.push_back(word_lane0(16'd10));
    run_pass(3, 0, 1, 0, 2, -1);
    chk("t2_lane0", last_out[PW-1:0], 16'd13);

    // Toggling valid and a mid-stream stall.
    for (int k = 0; k < 6; k++) fq.push_back({$urandom, $urandom, $urandom, $urandom});
    run_pass(6, 1, 1, 1, 1, -1);
    chk("t3_fq_left", fq.size(), 0);

    // Per-lane wrap.
    fq.push_back(word_all(16'h7FFF));
    run_pass(1, 1, 0, 0, 0, -1);
    fq.push_back(word_all(16'h0001));
    run_pass(1, 0, 1, 0, 0, -1);
`ifdef PSUM_DRAIN_RELU_EN
    chk("t4_wrap", last_out[PW-1:0], 16'h0000);
`else
    chk("t4_wrap", last_out[PW-1:0], 16'h8000);
`endif

    // num_nij=0 means a full 256-word pass.
    for (int k = 0; k < 256; k++) fq.push_back({$urandom, $urandom, $urandom, $urandom});
    run_pass(0, 1, 1, 2, 2, -1);
    chk("t5_fq_left", fq.size(), 0);

    // Reset after two of six pops, then accumulate onto the cleared bank.
    for (int k = 0; k < 6; k++) fq.push_back({$urandom, $urandom, $urandom, $urandom});
    run_pass(6, 1, 1, 0, 0, 2);
    reset = 1'b0;
    #1;
    chk("t6_rst_rd", ofifo_rd, 0);
    chk("t6_rst_ov", out_valid, 0);
    chk("t6_rst_dat", out_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    model_clear();
    fq.delete();
    @(negedge clk);
    reset = 1'b1; ofifo_valid = 1'b0;
    fq.push_back(word_all(16'd7));
    fq.push_back(word_all(16'd7));
    run_pass(2, 0, 1, 0, 0, -1);
    chk("t6_restart", last_out, word_all(16'd7));

    // Negative and positive lanes through the output stage.
    for (int c = 0; c < COL; c++) wv[c*PW +: PW] = (c % 2 == 0) ? 16'hFFFD : 16'h0004;
    fq.push_back(wv);
    run_pass(1, 1, 1, 0, 0, -1);
`ifdef PSUM_DRAIN_RELU_EN
    chk("t7_neg_lane", last_out[PW-1:0], 16'h0000);
`else
    chk("t7_neg_lane", last_out[PW-1:0], 16'hFFFD);
`endif
    chk("t7_pos_lane", last_out[2*PW-1:PW], 16'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
